// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one outstanding data-memory access over a req/gnt + rvalid
// handshake, with byte-lane formatting, illegal-op detection and an access timeout.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ex_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] aluResult,
    input  logic [31:0] storeData,
    input  logic [4:0]  rd,
    input  logic        RegWrite,
    input  logic [1:0]  MemtoReg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] readData,
    output logic [31:0] memAddress,
    output logic [4:0]  rd_out,
    output logic        RegWrite_out,
    output logic [1:0]  MemtoReg_out,
    output logic        stall,
    output logic        req_fault,
    output logic        timeout_fault,
    output logic [1:0]  state_dbg
);

    // Handshake: in REQ, dmem_req/addr/we/wdata/be are held stable until the cycle
    // dmem_gnt=1, which is the transfer cycle; load data is taken only on dmem_rvalid in WAIT.
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    localparam logic [31:0] CNT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [31:0] wait_cnt;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic [2:0]  cap_funct3;
    logic [4:0]  cap_rd;
    logic        cap_regwrite;
    logic [1:0]  cap_memtoreg;
    logic        cap_store;

    logic        mem_op;
    logic        op_illegal;
    logic        accept;
    logic        store_done;
    logic        load_gnt;
    logic        load_done;
    logic        done;
    logic        timeout;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    assign state_dbg = state;

    assign mem_op     = ex_valid & (MemRead | MemWrite);
    assign accept     = (state == IDLE) & mem_op & ~op_illegal;
    assign store_done = (state == REQ) & cap_store & dmem_gnt;
    assign load_gnt   = (state == REQ) & ~cap_store & dmem_gnt;
    assign load_done  = (state == WAIT) & dmem_rvalid;
    assign done       = store_done | load_done;
    assign timeout    = (state != IDLE) & ~done & (wait_cnt == CNT_LAST);

    always_comb begin
        op_illegal = 1'b0;
        if (MemRead && MemWrite) begin
            op_illegal = 1'b1;
        end else if (MemRead) begin
            case (funct3)
                3'b000, 3'b100: op_illegal = 1'b0;
                3'b001, 3'b101: op_illegal = aluResult[0];
                3'b010:         op_illegal = |aluResult[1:0];
                default:        op_illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                3'b000:  op_illegal = 1'b0;
                3'b001:  op_illegal = aluResult[0];
                3'b010:  op_illegal = |aluResult[1:0];
                default: op_illegal = 1'b1;
            endcase
        end
    end

    // Store lanes are formatted once at accept time so REQ drives stable registers.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = 32'd0;
        if (MemWrite) begin
            case (funct3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << aluResult[1:0];
                    st_wdata = {4{storeData[7:0]}};
                end
                2'b01: begin
                    st_be    = aluResult[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{storeData[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = storeData;
                end
            endcase
        end
    end

    always_comb begin
        case (cap_addr[1:0])
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = cap_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (cap_funct3)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {24'd0, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_data = {16'd0, ld_half};
            default: load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            wait_cnt     <= 32'd0;
            cap_addr     <= 32'd0;
            cap_wdata    <= 32'd0;
            cap_be       <= 4'd0;
            cap_funct3   <= 3'd0;
            cap_rd       <= 5'd0;
            cap_regwrite <= 1'b0;
            cap_memtoreg <= 2'd0;
            cap_store    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= REQ;
                        wait_cnt     <= 32'd0;
                        cap_addr     <= aluResult;
                        cap_wdata    <= st_wdata;
                        cap_be       <= st_be;
                        cap_funct3   <= funct3;
                        cap_rd       <= rd;
                        cap_regwrite <= RegWrite;
                        cap_memtoreg <= MemtoReg;
                        cap_store    <= MemWrite;
                    end
                end
                REQ: begin
                    // A load granted in its last allowed cycle still times out.
                    if (store_done || timeout) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                        if (load_gnt) state <= WAIT;
                    end
                end
                WAIT: begin
                    if (load_done || timeout) state <= IDLE;
                    else                      wait_cnt <= wait_cnt + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        dmem_addr     = 32'd0;
        dmem_wdata    = 32'd0;
        dmem_be       = 4'd0;
        readData      = 32'd0;
        memAddress    = 32'd0;
        rd_out        = 5'd0;
        RegWrite_out  = 1'b0;
        MemtoReg_out  = 2'd0;
        stall         = 1'b0;
        req_fault     = 1'b0;
        timeout_fault = 1'b0;
        // Gated by rstn so the pass-through path also shows a bubble while in reset.
        if (rstn) begin
            case (state)
                IDLE: begin
                    if (!mem_op) begin
                        memAddress   = aluResult;
                        rd_out       = rd;
                        RegWrite_out = RegWrite & ex_valid;
                        MemtoReg_out = MemtoReg;
                    end else if (op_illegal) begin
                        req_fault = 1'b1;
                    end else begin
                        stall = 1'b1;
                    end
                end
                REQ: begin
                    dmem_req   = 1'b1;
                    dmem_we    = cap_store;
                    dmem_addr  = {cap_addr[31:2], 2'b00};
                    dmem_wdata = cap_wdata;
                    dmem_be    = cap_be;
                end
                default: ;
            endcase
            if (state != IDLE) begin
                if (done) begin
                    memAddress   = cap_addr;
                    rd_out       = cap_rd;
                    RegWrite_out = cap_regwrite;
                    MemtoReg_out = cap_memtoreg;
                    readData     = cap_store ? 32'd0 : load_data;
                end else if (timeout) begin
                    timeout_fault = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
        end
    end

endmodule
